psiso_design: RTL and testbench



---
 rtl/psiso_design.sv | 29 ++
 tb/tb_psiso_design.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/psiso_design.sv
// Parallel-or-serial-in, serial-out shift register.
// Each edge either loads a whole word or shifts right, with serial data entering at the MSB.
module psiso_design #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_p,
    input  logic             i_s,
    input  logic             i_shift,
    output logic             o_q
);

    logic [WIDTH-1:0] sr;

    // No hold mode: every edge outside reset either loads or shifts.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sr <= '0;
        end else if (i_shift) begin
            sr <= {i_s, sr[WIDTH-1:1]};
        end else begin
            sr <= i_p;
        end
    end

    assign o_q = sr[0];

endmodule

// File: tb/tb_psiso_design.sv
// Self-checking bench for psiso_design: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a bit-queue reference model.
module tb_psiso_design;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [3:0] p4;
    logic       s4;
    logic       sh4;
    logic       q4;
    logic [7:0] p8;
    logic       s8;
    logic       sh8;
    logic       q8;

    int checks = 0;
    int passes = 0;

    // Reference model: queue element 0 is the bit currently on o_q.
    bit m4[$];
    bit m8[$];

    typedef struct {
        bit       rst;
        bit       shift;
        bit       s;
        bit [3:0] p;
        bit       exp_q;
    } vec_t;

    vec_t vecs[$];

    always #5 i_clk = ~i_clk;

    psiso_design #(.WIDTH(4)) dut4 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_p     (p4),
        .i_s     (s4),
        .i_shift (sh4),
        .o_q     (q4)
    );

    psiso_design #(.WIDTH(8)) dut8 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_p     (p8),
        .i_s     (s8),
        .i_shift (sh8),
        .o_q     (q8)
    );

    task automatic check_output(input string name, input logic actual, input logic expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %b, expected %b at t=%0t", name, actual, expected, $time);
        end
    endtask

    function automatic void model_clear();
        m4.delete();
        m8.delete();
        for (int i = 0; i < 4; i++) m4.push_back(1'b0);
        for (int i = 0; i < 8; i++) m8.push_back(1'b0);
    endfunction

    function automatic void model_edge(input bit rst, input bit shift4, input bit ser4, input bit [3:0] par4,
                                       input bit shift8, input bit ser8, input bit [7:0] par8);
        if (!rst) begin
            model_clear();
        end else begin
            if (shift4) begin
                void'(m4.pop_front());
                m4.push_back(ser4);
            end else begin
                m4.delete();
                for (int i = 0; i < 4; i++) m4.push_back(par4[i]);
            end
            if (shift8) begin
                void'(m8.pop_front());
                m8.push_back(ser8);
            end else begin
                m8.delete();
                for (int i = 0; i < 8; i++) m8.push_back(par8[i]);
            end
        end
    endfunction

    // Drive at the falling edge, clock once, and return at the next falling edge for sampling.
    task automatic apply_stimulus(input bit rst, input bit shift4, input bit ser4, input bit [3:0] par4,
                                  input bit shift8, input bit ser8, input bit [7:0] par8);
        i_rst = rst;
        sh4   = shift4;
        s4    = ser4;
        p4    = par4;
        sh8   = shift8;
        s8    = ser8;
        p8    = par8;
        @(posedge i_clk);
        model_edge(rst, shift4, ser4, par4, shift8, ser8, par8);
        @(negedge i_clk);
    endtask

    function automatic void add_vec(input bit rst, input bit shift, input bit s, input bit [3:0] p, input bit exp_q);
        vec_t v;
        v.rst   = rst;
        v.shift = shift;
        v.s     = s;
        v.p     = p;
        v.exp_q = exp_q;
        vecs.push_back(v);
    endfunction

    initial begin
        bit [7:0] a5;
        bit [7:0] exp8;
        bit       r;
        bit       h4;
        bit       b4;
        bit [3:0] w4;
        bit       h8;
        bit       b8;
        bit [7:0] w8;

        // Reset held with arbitrary inputs, then load 1010 and serialize.
        add_vec(0, 0, 1, 4'b1111, 0);
        add_vec(0, 1, 1, 4'b0101, 0);
        add_vec(1, 0, 1, 4'b1010, 0);
        add_vec(1, 1, 0, 4'b0000, 1);
        add_vec(1, 1, 0, 4'b1111, 0);
        add_vec(1, 1, 0, 4'b0000, 1);
        add_vec(1, 1, 0, 4'b1111, 0);
        add_vec(1, 1, 0, 4'b0000, 0);
        add_vec(1, 1, 0, 4'b0000, 0);
        // Serial delay line: 1,0,0,1 captured, reappearing three edges later.
        add_vec(0, 1, 1, 4'b1111, 0);
        add_vec(1, 1, 1, 4'b0000, 0);
        add_vec(1, 1, 0, 4'b1111, 0);
        add_vec(1, 1, 0, 4'b0000, 0);
        add_vec(1, 1, 1, 4'b1111, 1);
        add_vec(1, 1, 0, 4'b0000, 0);
        add_vec(1, 1, 0, 4'b0000, 0);
        add_vec(1, 1, 0, 4'b0000, 1);
        add_vec(1, 1, 0, 4'b0000, 0);
        // Load override in the middle of a shift sequence.
        add_vec(1, 1, 1, 4'b0000, 0);
        add_vec(1, 1, 1, 4'b0000, 0);
        add_vec(1, 0, 1, 4'b0110, 0);
        add_vec(1, 1, 0, 4'b1001, 1);
        add_vec(1, 1, 0, 4'b1001, 1);
        add_vec(1, 1, 0, 4'b1001, 0);

        // Reset asserted before any clock edge must already force the output low.
        i_rst = 1'b0;
        sh4 = 1'b0; s4 = 1'b1; p4 = 4'b1111;
        sh8 = 1'b0; s8 = 1'b1; p8 = 8'hFF;
        model_clear();
        #1;
        check_output("reset_before_clock_w4", q4, 1'b0);
        check_output("reset_before_clock_w8", q8, 1'b0);
        @(negedge i_clk);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst, vecs[i].shift, vecs[i].s, vecs[i].p, 1'b1, 1'b0, 8'h00);
            check_output($sformatf("vec%0d", i), q4, vecs[i].exp_q);
        end

        // Async reset mid-shift: output must drop without a clock edge.
        apply_stimulus(1, 0, 0, 4'b1111, 1, 0, 8'h00);
        check_output("async_load_1111", q4, 1'b1);
        apply_stimulus(1, 1, 1, 4'b0000, 1, 0, 8'h00);
        check_output("async_shift_once", q4, 1'b1);
        #2;
        i_rst = 1'b0;
        model_clear();
        #1;
        check_output("async_drop_before_edge", q4, 1'b0);
        @(negedge i_clk);
        check_output("async_held_through_edge", q4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1, 1, 0, 4'b1111, 1, 0, 8'h00);
            check_output($sformatf("async_after_release%0d", k), q4, 1'b0);
        end

        // WIDTH=8 serialization of A5, LSB first.
        a5 = 8'hA5;
        exp8 = 8'b1010_0101;
        apply_stimulus(1, 1, 0, 4'b0000, 0, 1, a5);
        check_output("w8_load_a5", q8, exp8[0]);
        for (int k = 1; k < 8; k++) begin
            apply_stimulus(1, 1, 0, 4'b0000, 1, 0, 8'h00);
            check_output($sformatf("w8_shift%0d", k), q8, exp8[k]);
        end

        // Randomized traffic against the queue model, with occasional reset edges.
        for (int k = 0; k < 300; k++) begin
            r  = ($urandom_range(0, 39) != 0);
            h4 = $urandom_range(0, 3) != 0;
            b4 = $urandom_range(0, 1);
            w4 = $urandom_range(0, 15);
            h8 = $urandom_range(0, 5) != 0;
            b8 = $urandom_range(0, 1);
            w8 = $urandom_range(0, 255);
            apply_stimulus(r, h4, b4, w4, h8, b8, w8);
            check_output($sformatf("rand_w4_%0d", k), q4, m4[0]);
            check_output($sformatf("rand_w8_%0d", k), q8, m8[0]);
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
